// File: rtl/window_pkg.sv
// rtl/window_pkg.sv - shared defaults and grid indexing for the sliding window buffer
package window_pkg;

    localparam int LINE_W_DEF = 640;
    localparam int WIN_DEF    = 11;
    localparam int PIX_W_DEF  = 1;

    // Flat index of window element (r, c); r=0 newest line, c=0 newest pixel
    function automatic int grid_idx(input int r, input int c, input int win);
        return r * win + c;
    endfunction

endpackage

// File: rtl/line_delay.sv
// rtl/line_delay.sv - clken-gated fixed delay of DEPTH accepted pixels, RAM based
module line_delay #(
    parameter int DEPTH = 629,
    parameter int PIX_W = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clken,
    input  logic [PIX_W-1:0] i_data,
    output logic [PIX_W-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Window as wide as the line: the taps alone already span a full line
            logic w_unused;
            assign w_unused = &{1'b0, clock, reset_n, clken};
            assign o_data   = i_data;
        end else begin : g_ram
            localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

            logic [PIX_W-1:0] r_mem [DEPTH];
            logic [PTR_W-1:0] r_ptr;

            // Circular storage: the oldest entry is read out while the newest overwrites it
            always_ff @(posedge clock) begin
                if (clken) begin
                    r_mem[r_ptr] <= i_data;
                end
            end

            // Ring pointer advances once per accepted pixel; storage itself is never cleared
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    r_ptr <= '0;
                end else if (clken) begin
                    r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
                end
            end

            assign o_data = r_mem[r_ptr];
        end
    endgenerate

endmodule

// File: rtl/window_buffer.sv
// rtl/window_buffer.sv - WIN x WIN sliding pixel window over a raster stream
module window_buffer
    import window_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int WIN    = WIN_DEF,
    parameter int PIX_W  = PIX_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clken,
    input  logic                     iSof,
    input  logic [PIX_W-1:0]         iPixel,
    output logic [WIN*WIN*PIX_W-1:0] oGrid,
    output logic                     oValid,
    output logic [PIX_W-1:0]         oCenter
);

    localparam int COL_W = $clog2(LINE_W);
    localparam int ROW_W = $clog2(WIN);
    localparam int CTR   = WIN / 2;

    generate
        if ((WIN % 2) == 0 || WIN < 3 || WIN > LINE_W || PIX_W < 1) begin : g_bad_params
            $error("window_buffer: WIN must be odd, 3 <= WIN <= LINE_W, PIX_W >= 1");
        end
    endgenerate

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_valid;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_last_col;
    logic             w_rows_full;

    logic [PIX_W-1:0] r_tap  [WIN][WIN];
    logic [PIX_W-1:0] w_head [WIN];

    // Position of the pixel being accepted; a start of frame forces it to (0,0)
    always_comb begin
        w_col = r_col;
        w_row = r_row;
        if (iSof) begin
            w_col = '0;
            w_row = '0;
        end
    end

    assign w_last_col  = (w_col == COL_W'(LINE_W - 1));
    assign w_rows_full = (w_row == ROW_W'(WIN - 1));

    // Column / row-fill counters and the window-complete flag for the accepted pixel
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
        end else if (clken) begin
            r_valid <= w_rows_full && (w_col >= COL_W'(WIN - 1));
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_rows_full ? w_row : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    // Window taps: every row shifts one column, column 0 takes that row's newest pixel
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    r_tap[r][c] <= '0;
                end
            end
        end else if (clken) begin
            for (int r = 0; r < WIN; r++) begin
                r_tap[r][0] <= w_head[r];
                for (int c = 1; c < WIN; c++) begin
                    r_tap[r][c] <= r_tap[r][c-1];
                end
            end
        end
    end

    // Row r's newest pixel is row r-1's oldest tap delayed by the rest of a line,
    // so each row sits exactly LINE_W accepted pixels behind the row above it
    assign w_head[0] = iPixel;

    generate
        for (genvar g = 1; g < WIN; g++) begin : g_line
            line_delay #(
                .DEPTH (LINE_W - WIN),
                .PIX_W (PIX_W)
            ) u_line_delay (
                .clock   (clock),
                .reset_n (reset_n),
                .clken   (clken),
                .i_data  (r_tap[g-1][WIN-1]),
                .o_data  (w_head[g])
            );
        end

        for (genvar gr = 0; gr < WIN; gr++) begin : g_row
            for (genvar gc = 0; gc < WIN; gc++) begin : g_col
                localparam int K = grid_idx(gr, gc, WIN);
                assign oGrid[K*PIX_W +: PIX_W] = r_tap[gr][gc];
            end
        end
    endgenerate

    assign oValid  = r_valid;
    assign oCenter = r_tap[CTR][CTR];

endmodule
